// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_pkg
//  Description : Shared types and constants for the banked register file.
//  Revision    : 1.0 - initial banked, multi-port release
// ============================================================================
package regfile_pkg;

   localparam int XLEN_DEF  = 32;
   localparam int NREG_DEF  = 32;
   localparam int NBANK_DEF = 2;

   // Bank select needs at least one bit even for a single-bank build.
   function automatic int bank_width(input int nbank);
      return (nbank > 1) ? $clog2(nbank) : 1;
   endfunction

   localparam int BW_DEF = bank_width(NBANK_DEF);

   typedef logic [BW_DEF-1:0] bank_t;

   localparam bank_t BANK_INT = bank_t'(0);
   localparam bank_t BANK_FP  = bank_t'(1);

   // Decode drives rd_bank from these: FP ops and FP stores read the FP bank.
   localparam logic [6:0] OP_FP     = 7'b1010011;
   localparam logic [6:0] OP_FSTORE = 7'b0100111;

endpackage
`default_nettype wire

// File: rtl/banked_regfile_sb_if.sv
`default_nettype none
// ============================================================================
//  Module      : banked_regfile_sb_if
//  Description : Decode/writeback bus of the banked register file.
//  Revision    : 1.0 - initial banked, multi-port release
// ============================================================================
interface banked_regfile_sb_if
   import regfile_pkg::*;
#(
   parameter int XLEN   = XLEN_DEF,
   parameter int NREG   = NREG_DEF,
   parameter int NBANK  = NBANK_DEF,
   parameter int NREAD  = 3,
   parameter int NWRITE = 2
);
   localparam int AW = $clog2(NREG);
   localparam int BW = bank_width(NBANK);

   logic [NREAD*BW-1:0]     rd_bank;
   logic [NREAD*AW-1:0]     rd_addr;
   logic [NREAD*XLEN-1:0]   rd_data;
   logic [NREAD-1:0]        rd_busy;
   logic [NWRITE-1:0]       wr_en;
   logic [NWRITE*BW-1:0]    wr_bank;
   logic [NWRITE*AW-1:0]    wr_addr;
   logic [NWRITE*XLEN-1:0]  wr_data;
   logic                    iss_en;
   logic [BW-1:0]           iss_bank;
   logic [AW-1:0]           iss_addr;
   logic                    flush;
   logic                    waw_err;
   logic                    wr_collide;

   modport master (
      output rd_bank, rd_addr, wr_en, wr_bank, wr_addr, wr_data,
             iss_en, iss_bank, iss_addr, flush,
      input  rd_data, rd_busy, waw_err, wr_collide
   );

   modport slave (
      input  rd_bank, rd_addr, wr_en, wr_bank, wr_addr, wr_data,
             iss_en, iss_bank, iss_addr, flush,
      output rd_data, rd_busy, waw_err, wr_collide
   );

endinterface
`default_nettype wire

// File: rtl/regfile_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_scoreboard
//  Description : Per-register pending-write bits, WAW detection, busy lookup.
//  Revision    : 1.0 - initial banked, multi-port release
// ============================================================================
module regfile_scoreboard
   import regfile_pkg::*;
#(
   parameter int NREG   = NREG_DEF,
   parameter int NBANK  = NBANK_DEF,
   parameter int NREAD  = 3,
   parameter int NWRITE = 2,
   parameter int AW     = $clog2(NREG),
   parameter int BW     = bank_width(NBANK)
) (
   input  wire logic                   clk,
   input  wire logic                   rst,
   input  wire logic                   i_flush,
   input  wire logic                   i_iss_en,
   input  wire logic [BW-1:0]          i_iss_bank,
   input  wire logic [AW-1:0]          i_iss_addr,
   input  wire logic [NWRITE-1:0]      i_wr_valid,
   input  wire logic [NWRITE*BW-1:0]   i_wr_bank,
   input  wire logic [NWRITE*AW-1:0]   i_wr_addr,
   input  wire logic [NREAD*BW-1:0]    i_rd_bank,
   input  wire logic [NREAD*AW-1:0]    i_rd_addr,
   output logic      [NREAD-1:0]       o_rd_busy,
   output logic                        o_waw_err
);

   logic [NREG-1:0] r_pend [NBANK];
   logic            r_waw_err;
   logic            w_iss_valid;
   logic            w_iss_hit;

   assign w_iss_valid = i_iss_en && (int'(i_iss_bank) < NBANK) &&
                        !((i_iss_bank == BW'(BANK_INT)) && (i_iss_addr == '0));
   assign w_iss_hit   = w_iss_valid && r_pend[i_iss_bank][i_iss_addr];

   // Issue is applied after the write clears so a new owner keeps the bit.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int b = 0; b < NBANK; b++) r_pend[b] <= '0;
         r_waw_err <= 1'b0;
      end else begin
         r_waw_err <= w_iss_hit;
         if (i_flush) begin
            for (int b = 0; b < NBANK; b++) r_pend[b] <= '0;
         end else begin
            for (int w = 0; w < NWRITE; w++)
               if (i_wr_valid[w])
                  r_pend[i_wr_bank[w*BW +: BW]][i_wr_addr[w*AW +: AW]] <= 1'b0;
            if (w_iss_valid)
               r_pend[i_iss_bank][i_iss_addr] <= 1'b1;
         end
      end
   end

   always_comb begin
      o_rd_busy = '0;
      for (int r = 0; r < NREAD; r++) begin
         if (int'(i_rd_bank[r*BW +: BW]) < NBANK) begin
            o_rd_busy[r] = r_pend[i_rd_bank[r*BW +: BW]][i_rd_addr[r*AW +: AW]];
            for (int w = 0; w < NWRITE; w++)
               if (i_wr_valid[w] &&
                   (i_wr_bank[w*BW +: BW] == i_rd_bank[r*BW +: BW]) &&
                   (i_wr_addr[w*AW +: AW] == i_rd_addr[r*AW +: AW]))
                  o_rd_busy[r] = 1'b0;
         end
      end
   end

   assign o_waw_err = r_waw_err;

endmodule
`default_nettype wire

// File: rtl/banked_regfile_sb.sv
`default_nettype none
// ============================================================================
//  Module      : banked_regfile_sb
//  Description : Banked int/FP register file with write bypass and scoreboard.
//  Revision    : 1.0 - initial banked, multi-port release
// ============================================================================
module banked_regfile_sb
   import regfile_pkg::*;
#(
   parameter int XLEN   = XLEN_DEF,
   parameter int NREG   = NREG_DEF,
   parameter int NBANK  = NBANK_DEF,
   parameter int NREAD  = 3,
   parameter int NWRITE = 2
) (
   input  wire logic          clk,
   input  wire logic          rst,
   banked_regfile_sb_if.slave bus
);

   localparam int AW = $clog2(NREG);
   localparam int BW = bank_width(NBANK);

   logic [XLEN-1:0]        r_regs [NBANK][NREG];
   logic                   r_wr_collide;
   logic                   w_collide;
   logic [NREAD-1:0]       w_rd_busy;
   logic                   w_waw_err;
   wire  [NWRITE-1:0]      w_wr_valid;
   wire  [NWRITE-1:0]      w_wr_store;
   wire  [NREAD*XLEN-1:0]  w_rd_data;

   // Valid ports take part in bypass, collision and scoreboard clear; int x0 is never stored.
   for (genvar w = 0; w < NWRITE; w++) begin : g_wr
      assign w_wr_valid[w] = bus.wr_en[w] && (int'(bus.wr_bank[w*BW +: BW]) < NBANK);
      assign w_wr_store[w] = w_wr_valid[w] &&
                             !((bus.wr_bank[w*BW +: BW] == BW'(BANK_INT)) &&
                               (bus.wr_addr[w*AW +: AW] == '0));
   end

   // Ascending loop: the highest-index port's assignment is the one that lands.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int b = 0; b < NBANK; b++)
            for (int r = 0; r < NREG; r++)
               r_regs[b][r] <= '0;
      end else begin
         for (int w = 0; w < NWRITE; w++)
            if (w_wr_store[w])
               r_regs[bus.wr_bank[w*BW +: BW]][bus.wr_addr[w*AW +: AW]] <=
                  bus.wr_data[w*XLEN +: XLEN];
      end
   end

   always_comb begin
      w_collide = 1'b0;
      for (int i = 0; i < NWRITE; i++)
         for (int j = i + 1; j < NWRITE; j++)
            if (w_wr_valid[i] && w_wr_valid[j] &&
                (bus.wr_bank[i*BW +: BW] == bus.wr_bank[j*BW +: BW]) &&
                (bus.wr_addr[i*AW +: AW] == bus.wr_addr[j*AW +: AW]))
               w_collide = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) r_wr_collide <= 1'b0;
      else     r_wr_collide <= w_collide;
   end

   for (genvar r = 0; r < NREAD; r++) begin : g_rd
      logic [BW-1:0]   w_bank;
      logic [AW-1:0]   w_addr;
      logic [XLEN-1:0] w_data;

      assign w_bank = bus.rd_bank[r*BW +: BW];
      assign w_addr = bus.rd_addr[r*AW +: AW];

      always_comb begin
         w_data = '0;
         if (int'(w_bank) < NBANK) begin
            w_data = r_regs[w_bank][w_addr];
            for (int w = 0; w < NWRITE; w++)
               if (w_wr_valid[w] && (bus.wr_bank[w*BW +: BW] == w_bank) &&
                   (bus.wr_addr[w*AW +: AW] == w_addr))
                  w_data = bus.wr_data[w*XLEN +: XLEN];
            if ((w_bank == BW'(BANK_INT)) && (w_addr == '0))
               w_data = '0;
         end
      end

      assign w_rd_data[r*XLEN +: XLEN] = w_data;
   end

   regfile_scoreboard #(
      .NREG   (NREG),
      .NBANK  (NBANK),
      .NREAD  (NREAD),
      .NWRITE (NWRITE),
      .AW     (AW),
      .BW     (BW)
   ) u_scoreboard (
      .clk        (clk),
      .rst        (rst),
      .i_flush    (bus.flush),
      .i_iss_en   (bus.iss_en),
      .i_iss_bank (bus.iss_bank),
      .i_iss_addr (bus.iss_addr),
      .i_wr_valid (w_wr_valid),
      .i_wr_bank  (bus.wr_bank),
      .i_wr_addr  (bus.wr_addr),
      .i_rd_bank  (bus.rd_bank),
      .i_rd_addr  (bus.rd_addr),
      .o_rd_busy  (w_rd_busy),
      .o_waw_err  (w_waw_err)
   );

   assign bus.rd_data    = w_rd_data;
   assign bus.rd_busy    = w_rd_busy;
   assign bus.waw_err    = w_waw_err;
   assign bus.wr_collide = r_wr_collide;

endmodule
`default_nettype wire

// File: tb/tb_banked_regfile_sb.sv
`default_nettype none
// ============================================================================
//  Module      : tb_banked_regfile_sb
//  Description : Directed vector table plus random traffic against a model.
//  Revision    : 1.0 - initial banked, multi-port release
// ============================================================================
module tb_banked_regfile_sb;

   typedef struct packed {
      bit              rst;
      bit [1:0]        we;
      bit [1:0]        wb;
      logic [1:0][4:0] wa;
      logic [1:0][31:0] wd;
      bit              ie;
      bit              ib;
      logic [4:0]      ia;
      bit              fl;
      bit [2:0]        rb;
      logic [2:0][4:0] ra;
   } stim_t;

   typedef struct packed {
      logic [2:0][31:0] d;
      logic [2:0]       busy;
      logic             waw;
      logic             col;
   } exp_t;

   typedef struct packed {
      bit    chk;
      stim_t s;
      exp_t  e;
   } vec_t;

   logic clk = 1'b0;
   logic rst;
   int   n_pass  = 0;
   int   n_total = 0;

   logic [31:0] m_mem  [2][32];
   bit          m_pend [2][32];

   always #5 clk = ~clk;

   banked_regfile_sb_if bus ();

   banked_regfile_sb dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   // Reference rules: bypass from the highest matching port, int x0 reads 0.
   function automatic exp_t predict(input stim_t s);
      exp_t e;
      e = '0;
      for (int r = 0; r < 3; r++) begin
         logic [31:0] v;
         bit          hit;
         v   = m_mem[s.rb[r]][s.ra[r]];
         hit = 1'b0;
         for (int w = 0; w < 2; w++)
            if (s.we[w] && s.wb[w] == s.rb[r] && s.wa[w] == s.ra[r]) begin
               v   = s.wd[w];
               hit = 1'b1;
            end
         if (s.rb[r] == 1'b0 && s.ra[r] == 5'd0) v = 32'd0;
         e.d[r]    = v;
         e.busy[r] = m_pend[s.rb[r]][s.ra[r]] && !hit;
      end
      e.waw = !s.rst && s.ie && !(s.ib == 1'b0 && s.ia == 5'd0) && m_pend[s.ib][s.ia];
      e.col = !s.rst && s.we == 2'b11 && s.wb[0] == s.wb[1] && s.wa[0] == s.wa[1];
      return e;
   endfunction

   task automatic model_step(input stim_t s);
      if (s.rst) begin
         for (int b = 0; b < 2; b++)
            for (int r = 0; r < 32; r++) begin
               m_mem[b][r]  = 32'd0;
               m_pend[b][r] = 1'b0;
            end
      end else begin
         for (int w = 0; w < 2; w++)
            if (s.we[w] && !(s.wb[w] == 1'b0 && s.wa[w] == 5'd0))
               m_mem[s.wb[w]][s.wa[w]] = s.wd[w];
         if (s.fl) begin
            for (int b = 0; b < 2; b++)
               for (int r = 0; r < 32; r++) m_pend[b][r] = 1'b0;
         end else begin
            for (int w = 0; w < 2; w++)
               if (s.we[w]) m_pend[s.wb[w]][s.wa[w]] = 1'b0;
            if (s.ie && !(s.ib == 1'b0 && s.ia == 5'd0)) m_pend[s.ib][s.ia] = 1'b1;
         end
      end
   endtask

   // Entered on a falling edge: drive, check combinational outputs, clock, check pulses.
   task automatic run(input string tag, input vec_t v);
      rst          = v.s.rst;
      bus.wr_en    = v.s.we;
      bus.wr_bank  = v.s.wb;
      bus.wr_addr  = v.s.wa;
      bus.wr_data  = v.s.wd;
      bus.iss_en   = v.s.ie;
      bus.iss_bank = v.s.ib;
      bus.iss_addr = v.s.ia;
      bus.flush    = v.s.fl;
      bus.rd_bank  = v.s.rb;
      bus.rd_addr  = v.s.ra;
      #1;
      if (v.chk) begin
         check({tag, " rd_data"}, 96'(bus.rd_data), 96'(v.e.d));
         check({tag, " rd_busy"}, 96'(bus.rd_busy), 96'(v.e.busy));
      end
      @(posedge clk);
      #1;
      model_step(v.s);
      check({tag, " waw_err"}, 96'(bus.waw_err), 96'(v.e.waw));
      check({tag, " wr_collide"}, 96'(bus.wr_collide), 96'(v.e.col));
      @(negedge clk);
   endtask

   function automatic vec_t blank();
      vec_t v;
      v     = '0;
      v.chk = 1'b1;
      return v;
   endfunction

   function automatic vec_t rd(input vec_t vi, input bit b0, input logic [4:0] a0,
                               input bit b1, input logic [4:0] a1,
                               input bit b2, input logic [4:0] a2);
      vec_t v;
      v = vi;
      v.s.rb = {b2, b1, b0};
      v.s.ra = {a2, a1, a0};
      return v;
   endfunction

   function automatic vec_t wr(input vec_t vi, input int p, input bit b,
                               input logic [4:0] a, input logic [31:0] d);
      vec_t v;
      v = vi;
      v.s.we[p] = 1'b1;
      v.s.wb[p] = b;
      v.s.wa[p] = a;
      v.s.wd[p] = d;
      return v;
   endfunction

   function automatic vec_t iss(input vec_t vi, input bit b, input logic [4:0] a);
      vec_t v;
      v = vi;
      v.s.ie = 1'b1;
      v.s.ib = b;
      v.s.ia = a;
      return v;
   endfunction

   function automatic vec_t ex(input vec_t vi, input logic [31:0] d0, input logic [31:0] d1,
                               input logic [31:0] d2, input logic [2:0] busy,
                               input logic waw, input logic col);
      vec_t v;
      v = vi;
      v.e.d    = {d2, d1, d0};
      v.e.busy = busy;
      v.e.waw  = waw;
      v.e.col  = col;
      return v;
   endfunction

   initial begin
      vec_t  tbl[$];
      vec_t  v;
      stim_t s;

      for (int b = 0; b < 2; b++)
         for (int r = 0; r < 32; r++) begin
            m_mem[b][r]  = 32'd0;
            m_pend[b][r] = 1'b0;
         end

      // Reset and read back zeros
      v = blank(); v.s.rst = 1'b1; v.chk = 1'b0; tbl.push_back(v); tbl.push_back(v);
      v = ex(rd(blank(), 0, 5, 1, 5, 1, 31), 0, 0, 0, 3'b000, 0, 0); tbl.push_back(v);
      // Write with same-cycle bypass, then stored value
      v = ex(rd(wr(blank(), 0, 0, 3, 32'hDEADBEEF), 0, 3, 1, 3, 0, 0),
             32'hDEADBEEF, 0, 0, 3'b000, 0, 0); tbl.push_back(v);
      v = ex(rd(blank(), 0, 3, 1, 3, 0, 0), 32'hDEADBEEF, 0, 0, 3'b000, 0, 0); tbl.push_back(v);
      // Int x0 hard-wired, FP f0 writable
      v = ex(rd(wr(wr(blank(), 0, 0, 0, 32'h1234), 1, 1, 0, 32'h3F800000), 0, 0, 1, 0, 0, 3),
             0, 32'h3F800000, 32'hDEADBEEF, 3'b000, 0, 0); tbl.push_back(v);
      v = ex(rd(blank(), 0, 0, 1, 0, 0, 3), 0, 32'h3F800000, 32'hDEADBEEF, 3'b000, 0, 0);
      tbl.push_back(v);
      // Two ports on f7: port 1 wins, collision pulses once
      v = ex(rd(wr(wr(blank(), 0, 1, 7, 32'h11111111), 1, 1, 7, 32'h22222222), 1, 7, 1, 7, 0, 0),
             32'h22222222, 32'h22222222, 0, 3'b000, 0, 1); tbl.push_back(v);
      v = ex(rd(blank(), 1, 7, 1, 7, 0, 0), 32'h22222222, 32'h22222222, 0, 3'b000, 0, 0);
      tbl.push_back(v);
      // Scoreboard set, bypass-clear, set-wins, WAW
      v = ex(rd(iss(blank(), 1, 2), 1, 2, 1, 7, 0, 0), 0, 32'h22222222, 0, 3'b000, 0, 0);
      tbl.push_back(v);
      v = ex(rd(blank(), 1, 2, 1, 2, 0, 0), 0, 0, 0, 3'b011, 0, 0); tbl.push_back(v);
      v = ex(rd(wr(blank(), 1, 1, 2, 32'hCAFEF00D), 1, 2, 1, 2, 1, 7),
             32'hCAFEF00D, 32'hCAFEF00D, 32'h22222222, 3'b000, 0, 0); tbl.push_back(v);
      v = ex(rd(blank(), 1, 2, 1, 2, 1, 7), 32'hCAFEF00D, 32'hCAFEF00D, 32'h22222222, 3'b000, 0, 0);
      tbl.push_back(v);
      v = ex(rd(wr(iss(blank(), 1, 2), 1, 1, 2, 32'hABCD0001), 1, 2, 0, 0, 0, 0),
             32'hABCD0001, 0, 0, 3'b000, 0, 0); tbl.push_back(v);
      v = ex(rd(blank(), 1, 2, 0, 0, 0, 0), 32'hABCD0001, 0, 0, 3'b001, 0, 0); tbl.push_back(v);
      v = ex(rd(iss(blank(), 1, 2), 1, 2, 0, 0, 0, 0), 32'hABCD0001, 0, 0, 3'b001, 1, 0);
      tbl.push_back(v);
      v = ex(rd(blank(), 1, 2, 0, 0, 0, 0), 32'hABCD0001, 0, 0, 3'b001, 0, 0); tbl.push_back(v);
      // Flush with simultaneous issue and write, then reset overriding a write
      v = ex(rd(iss(blank(), 0, 4), 1, 2, 0, 4, 0, 0), 32'hABCD0001, 0, 0, 3'b001, 0, 0);
      tbl.push_back(v);
      v = ex(rd(iss(blank(), 1, 9), 0, 4, 1, 9, 1, 2), 0, 0, 32'hABCD0001, 3'b101, 0, 0);
      tbl.push_back(v);
      v = rd(wr(iss(blank(), 0, 6), 0, 0, 4, 32'h55), 0, 4, 1, 9, 0, 6);
      v.s.fl = 1'b1;
      v = ex(v, 32'h55, 0, 0, 3'b010, 0, 0); tbl.push_back(v);
      v = ex(rd(blank(), 0, 4, 1, 9, 0, 6), 32'h55, 0, 0, 3'b000, 0, 0); tbl.push_back(v);
      v = rd(wr(blank(), 0, 0, 8, 32'h99), 0, 8, 0, 4, 1, 2);
      v.s.rst = 1'b1;
      v = ex(v, 32'h99, 32'h55, 32'hABCD0001, 3'b000, 0, 0); tbl.push_back(v);
      v = ex(rd(blank(), 0, 8, 0, 4, 1, 2), 0, 0, 0, 3'b000, 0, 0); tbl.push_back(v);

      @(negedge clk);
      for (int i = 0; i < tbl.size(); i++) run($sformatf("vec%0d", i), tbl[i]);

      // Narrow address range keeps write/read/issue overlaps frequent.
      for (int i = 0; i < 600; i++) begin
         s       = '0;
         s.rst   = ($urandom_range(0, 63) == 0);
         s.we    = 2'($urandom);
         s.wb    = 2'($urandom);
         s.wa[0] = 5'($urandom_range(0, 7));
         s.wa[1] = 5'($urandom_range(0, 7));
         s.wd[0] = $urandom;
         s.wd[1] = $urandom;
         s.ie    = ($urandom_range(0, 2) == 0);
         s.ib    = 1'($urandom);
         s.ia    = 5'($urandom_range(0, 7));
         s.fl    = ($urandom_range(0, 15) == 0);
         s.rb    = 3'($urandom);
         for (int r = 0; r < 3; r++) s.ra[r] = 5'($urandom_range(0, 7));
         v     = '0;
         v.chk = 1'b1;
         v.s   = s;
         v.e   = predict(s);
         run($sformatf("rnd%0d", i), v);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
      $fatal(1);
   end

endmodule
`default_nettype wire
